fpu_add_sub_seq: RTL

- Multi-cycle sequencer for the single-precision FP add/sub datapath.
- Accepts one operation at a time via start/ready handshake and resolves the rounding mode (including DYN from the frm CSR).
- Steps the datapath through unpack, iterative alignment, add, iterative normalisation, rounding (with the rounder's ±1 adjust) and post-round renormalisation.
- Holds the result until writeback accepts it. Sits between the FPU issue logic and the add/sub datapath; owns no mantissa/exponent storage.

---
 rtl/fpu_add_sub_seq.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fpu_add_sub_seq.sv
// Sequencer for the single-precision add/sub datapath: resolves rounding mode, then steps unpack, align, add, normalise, round, renormalise.
// Latency 1+A+1+N+1+P cycles to DONE; one op at a time, result held in DONE until result_ready_i, ready_o low while busy.
module fpu_add_sub_seq #(
  parameter int MAN_W     = 24,
  parameter int ALIGN_MAX = 26,
  parameter int DIFF_W    = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  output logic              ready_o,
  input  logic [2:0]        rm_i,
  input  logic [2:0]        frm_i,
  input  logic              flush_i,
  input  logic [DIFF_W-1:0] exp_diff_i,
  input  logic              special_i,
  input  logic              carry_i,
  input  logic              msb_i,
  input  logic              exp_min_i,
  input  logic              round_carry_i,
  output logic              unpack_en_o,
  output logic              align_shift_o,
  output logic              add_en_o,
  output logic              norm_right_o,
  output logic              norm_left_o,
  output logic              round_en_o,
  output logic [2:0]        rm_o,
  output logic              result_valid_o,
  input  logic              result_ready_i,
  output logic              illegal_rm_o,
  output logic              busy_o
);

  localparam int ACNT_W = $clog2(ALIGN_MAX + 1);
  localparam int NCNT_W = $clog2(MAN_W + 1);
  localparam logic [DIFF_W-1:0] ALIGN_CAP_D = DIFF_W'(ALIGN_MAX);
  localparam logic [ACNT_W-1:0] ALIGN_CAP_C = ACNT_W'(ALIGN_MAX);
  localparam logic [NCNT_W-1:0] NORM_LIM    = NCNT_W'(MAN_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_POSTNORM,
    S_DONE
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ACNT_W-1:0]   align_cnt;
  logic [NCNT_W-1:0]   norm_cnt;
  logic                postnorm_q;
  logic [2:0]          rm_res;
  logic                rm_bad;
  logic                norm_first;
  logic                norm_carry;
  logic                norm_stop;
  logic                norm_shift_l;

  // DYN (111) takes the CSR value, which may itself be a reserved encoding.
  always_comb begin
    rm_res = rm_i;
    rm_bad = 1'b0;
    if (rm_i == 3'b111) begin
      rm_res = frm_i;
      rm_bad = (frm_i > 3'b100);
    end else if (rm_i > 3'b100) begin
      rm_bad = 1'b1;
    end
  end

  // A carry is only meaningful before any left shift has happened.
  assign norm_first   = (norm_cnt == '0);
  assign norm_carry   = norm_first & carry_i;
  assign norm_stop    = msb_i | exp_min_i | (norm_cnt >= NORM_LIM);
  assign norm_shift_l = (state == S_NORM) & ~norm_carry & ~norm_stop;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start_i) state_nxt = rm_bad ? S_DONE : S_UNPACK;
      S_UNPACK: begin
        if (special_i)             state_nxt = S_DONE;
        else if (exp_diff_i == '0) state_nxt = S_ADD;
        else                       state_nxt = S_ALIGN;
      end
      S_ALIGN:    if (align_cnt <= ACNT_W'(1)) state_nxt = S_ADD;
      S_ADD:      state_nxt = S_NORM;
      S_NORM:     if (norm_carry | norm_stop) state_nxt = S_ROUND;
      S_ROUND:    state_nxt = round_carry_i ? S_POSTNORM : S_DONE;
      S_POSTNORM: state_nxt = S_DONE;
      S_DONE:     if (result_ready_i) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
    if (flush_i && (state != S_IDLE)) state_nxt = S_IDLE;
  end

  // Stage enables are registered decodes of the state being entered.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state          <= S_IDLE;
      align_cnt      <= '0;
      norm_cnt       <= '0;
      rm_o           <= 3'b000;
      illegal_rm_o   <= 1'b0;
      ready_o        <= 1'b1;
      unpack_en_o    <= 1'b0;
      align_shift_o  <= 1'b0;
      add_en_o       <= 1'b0;
      round_en_o     <= 1'b0;
      postnorm_q     <= 1'b0;
      result_valid_o <= 1'b0;
    end else begin
      state          <= state_nxt;
      ready_o        <= (state_nxt == S_IDLE);
      unpack_en_o    <= (state_nxt == S_UNPACK);
      align_shift_o  <= (state_nxt == S_ALIGN);
      add_en_o       <= (state_nxt == S_ADD);
      round_en_o     <= (state_nxt == S_ROUND);
      postnorm_q     <= (state_nxt == S_POSTNORM);
      result_valid_o <= (state_nxt == S_DONE);

      if ((state == S_IDLE) && start_i) begin
        illegal_rm_o <= rm_bad;
        if (!rm_bad) rm_o <= rm_res;
      end else if (state_nxt == S_IDLE) begin
        illegal_rm_o <= 1'b0;
      end

      if (state == S_UNPACK) begin
        align_cnt <= (exp_diff_i > ALIGN_CAP_D) ? ALIGN_CAP_C : ACNT_W'(exp_diff_i);
      end else if ((state == S_ALIGN) && (align_cnt != '0)) begin
        align_cnt <= align_cnt - ACNT_W'(1);
      end

      if (state == S_ADD) begin
        norm_cnt <= '0;
      end else if (norm_shift_l) begin
        norm_cnt <= norm_cnt + NCNT_W'(1);
      end
    end
  end

  assign norm_left_o  = norm_shift_l;
  assign norm_right_o = postnorm_q | ((state == S_NORM) & norm_carry);
  assign busy_o       = ~ready_o;

endmodule
